ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//   Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and resolves operand
//   forwarding. Performs ALU ops and an iterative 32-cycle MULT, then drives the EX/MEM pipeline register.
//   Asserts ex_stall so IF/ID and ID/EX hold while a multiply is in flight.
// PARAMETERS
//   DATA_W    32  datapath width; MULT takes DATA_W iterations
//   CNT_W      5  multiply iteration counter width (2**CNT_W >= DATA_W)
// PORTS
//   clk          in   1       clock; all state updates on the falling edge (pipeline register edge)
//   rst          in   1       synchronous, active-high reset, sampled on the same edge
//   rs_data      in   DATA_W  ID/EX Rs operand
//   rt_data      in   DATA_W  ID/EX Rt operand
//   imm          in   DATA_W  sign-extended immediate; imm[5:0] = funct for R-type
//   rs_addr      in   5       ID/EX Rs register number (forwarding compare)
//   rt_addr      in   5       ID/EX Rt register number
//   rd_addr      in   5       ID/EX Rd register number
//   alu_op       in   2       00 add, 01 sub, 10 R-type (decode funct), 11 or
//   alu_src, reg_dst, reg_w, mem_w, mem_r, mem_to_reg  in 1  ID/EX control bits
//   mem_reg_w    in   1       EX/MEM stage writes a register
//   mem_wr_addr  in   5       EX/MEM stage destination register
//   mem_fwd_data in   DATA_W  EX/MEM stage ALU result
//   wb_reg_w     in   1       MEM/WB stage writes a register
//   wb_wr_addr   in   5       MEM/WB stage destination register
//   wb_fwd_data  in   DATA_W  MEM/WB stage write-back value
//   ex_stall     out  1       1 = ID/EX and earlier stages hold; combinational
//   alu_result_out out DATA_W EX/MEM ALU or multiply result
//   store_data_out out DATA_W EX/MEM forwarded Rt value, used by SW
//   zero_out     out  1       EX/MEM: alu_result == 0 (BEQ)
//   wr_addr_out  out  5       EX/MEM destination: reg_dst ? rd_addr : rt_addr
//   reg_w_out, mem_w_out, mem_r_out, mem_to_reg_out  out 1  EX/MEM control bits
// BEHAVIOUR
//   - Reset: every output register is 0, FSM goes to IDLE, counter is 0. Reset mid-MULT aborts it, no write.
//   - Forwarding, per operand: MEM match first, then WB match, else the register value. A match needs
//     *_reg_w = 1, addr != 0 and addr == rs_addr/rt_addr. Operand B is imm when alu_src = 1, else forwarded Rt.
//   - Funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x18 mult.
//     Any other funct yields result 0 with control bits passed through.
//   - Arithmetic wraps modulo 2**DATA_W; overflow is ignored. MULT writes the low DATA_W bits of the signed product.
//   - Non-MULT ops take 1 cycle: EX/MEM captures the result on the next edge and ex_stall = 0.
//   - FSM IDLE: on a MULT, latch both operands, clear the accumulator, go to BUSY, cnt = 0, assert ex_stall.
//   - FSM BUSY: one shift-add per cycle, cnt++. ex_stall = 1 except when cnt == DATA_W-1. On that cycle:
//     * ex_stall = 0;
//     * EX/MEM captures the final product with its control bits;
//     * FSM returns to IDLE.
//   - MULT timing: DATA_W+1 cycles in EX, DATA_W stall cycles.
//   - Every cycle with ex_stall = 1, EX/MEM captures a bubble: reg_w/mem_w/mem_r/mem_to_reg = 0, data 0.
//   - Latched MULT operands are immune to forwarding-source changes during BUSY.
//   - Back-to-back MULTs: the second MULT is seen in IDLE on the cycle after completion. No lost cycle,
//     no double issue.
//   - wr_addr 0 passes through unchanged; the register file ignores writes to $0.
// CONFIGURATION
//   FORWARD_EN defined: forwarding as above.
//   FORWARD_EN undefined: operands are rs_data/rt_data directly, the mem_/wb_ forwarding inputs are
//   unused, and the software or hazard unit must insert NOPs.
// STRUCTURE
//   Package ex_pkg holds:
//     * ALU_OP_* codes (2 bit) and FUNCT_* constants (6 bit);
//     * ex_state_t {IDLE, BUSY};
//     * the bubble control constant.
//   Sub-module mul_iter: iterative signed multiplier with start/busy/last/product and its own counter.
//   The forwarding muxes, ALU and EX/MEM register stay in ex_stage.
// TESTING
//   - R-type add: rs=5, rt=7, funct 0x20 -> next edge alu_result_out=12, wr_addr_out=rd, reg_w_out=1.
//   - MEM forwarding priority: mem_wr_addr=wb_wr_addr=rs_addr=3, mem_fwd=10, wb_fwd=20, rt=1, add
//     -> 11. Repeat with rs_addr=0 -> uses rs_data.
//   - MULT: rs=-3, rt=7 -> ex_stall high 32 cycles and bubbles in EX/MEM. Then alu_result_out=-21
//     (0xFFFFFFEB) with reg_w_out=1. Next instruction follows with no gap.
//   - SW with alu_src=1: rs=0x100, imm=8 -> alu_result_out=0x108, mem_w_out=1, store_data_out=forwarded Rt.
//   - BEQ: alu_op=01, rs=rt=9 -> zero_out=1, alu_result_out=0.
//     slt: rs=-1, rt=1 -> 1.
//   - Reset at BUSY cnt=10 -> all outputs 0 next edge, ex_stall=0, no product written.
//     Build without FORWARD_EN -> forwarding test yields 1+rs_data.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS execute stage.
//   ALU_OP_* : 2-bit alu_op codes from the decoder.
//   FUNCT_*  : 6-bit R-type function codes (imm[5:0]).
//   ex_state_t : multiplier sequencer states.
//   ex_ctrl_t / CTRL_BUBBLE : EX/MEM control bundle and its bubble value.
//   fwd_hit() : forwarding match rule for one producer stage.
package ex_pkg;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_MULT = 6'h18;

  typedef enum logic {
    IDLE,
    BUSY
  } ex_state_t;

  typedef struct packed {
    logic reg_w;
    logic mem_w;
    logic mem_r;
    logic mem_to_reg;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  // A later stage supplies the operand when it writes a non-$0 register
  // that matches the operand's source register.
  function automatic logic fwd_hit(input logic       reg_w,
                                   input logic [4:0] wr_addr,
                                   input logic [4:0] src_addr);
    return reg_w && (wr_addr != 5'd0) && (wr_addr == src_addr);
  endfunction

endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative shift-add multiplier, one partial product per cycle.
//   clk, rst      : falling-edge clock, synchronous active-high reset
//   start_i       : accepted only in IDLE; latches a_i/b_i and enters BUSY
//   a_i, b_i      : multiplicand / multiplier
//   busy_o        : sequencer is in BUSY
//   last_o        : final iteration (cnt == DATA_W-1); product_o is valid
//   product_o     : low DATA_W bits of a_i*b_i (identical for signed and
//                   unsigned operands, so no sign correction is needed)
module mul_iter
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              last_o,
  output logic [DATA_W-1:0] product_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  ex_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sum;

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // The last iteration's add is taken combinationally so the product is
  // ready in the same cycle the stall drops.
  assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == BUSY);
  assign last_o    = (state_q == BUSY) && (cnt_q == CNT_LAST);
  assign product_o = sum;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
//   Resolves operand forwarding, runs the ALU or the iterative MULT and
//   drives the EX/MEM pipeline register. All state changes on the falling
//   clock edge; rst is synchronous and active-high on that edge.
//   Build option: FORWARD_EN defined enables EX/MEM and MEM/WB forwarding;
//   undefined, operands come straight from rs_data/rt_data.
// Ports:
//   rs_data/rt_data/imm, rs_addr/rt_addr/rd_addr, alu_op and the control
//   bits alu_src/reg_dst/reg_w/mem_w/mem_r/mem_to_reg : ID/EX register
//   mem_reg_w/mem_wr_addr/mem_fwd_data : EX/MEM forwarding source
//   wb_reg_w/wb_wr_addr/wb_fwd_data    : MEM/WB forwarding source
//   ex_stall : combinational hold request while a MULT is in flight
//   alu_result_out, store_data_out, zero_out, wr_addr_out, reg_w_out,
//   mem_w_out, mem_r_out, mem_to_reg_out : EX/MEM register outputs
module ex_stage
  import ex_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        rd_addr,
  input  logic [1:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              reg_w,
  input  logic              mem_w,
  input  logic              mem_r,
  input  logic              mem_to_reg,
  input  logic              mem_reg_w,
  input  logic [4:0]        mem_wr_addr,
  input  logic [DATA_W-1:0] mem_fwd_data,
  input  logic              wb_reg_w,
  input  logic [4:0]        wb_wr_addr,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              ex_stall,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic              zero_out,
  output logic [4:0]        wr_addr_out,
  output logic              reg_w_out,
  output logic              mem_w_out,
  output logic              mem_r_out,
  output logic              mem_to_reg_out
);

  logic [DATA_W-1:0] op_a, rt_fwd, op_b;
  logic [DATA_W-1:0] alu_res, ex_result;
  logic [5:0]        funct;
  logic              is_mult, mul_start, mul_busy, mul_last;
  logic [DATA_W-1:0] mul_product;

  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              zero_q, zero_d;
  logic [4:0]        wr_addr_q, wr_addr_d;
  ex_ctrl_t          ctrl_q, ctrl_d;

`ifdef FORWARD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    op_a = rs_data;
    if (fwd_hit(mem_reg_w, mem_wr_addr, rs_addr))      op_a = mem_fwd_data;
    else if (fwd_hit(wb_reg_w, wb_wr_addr, rs_addr))   op_a = wb_fwd_data;
    rt_fwd = rt_data;
    if (fwd_hit(mem_reg_w, mem_wr_addr, rt_addr))      rt_fwd = mem_fwd_data;
    else if (fwd_hit(wb_reg_w, wb_wr_addr, rt_addr))   rt_fwd = wb_fwd_data;
  end
`else
  assign op_a   = rs_data;
  assign rt_fwd = rt_data;
  logic unused_fwd;
  assign unused_fwd = ^{rs_addr, mem_reg_w, mem_wr_addr, mem_fwd_data,
                        wb_reg_w, wb_wr_addr, wb_fwd_data};
`endif

  assign op_b    = alu_src ? imm : rt_fwd;
  assign funct   = imm[5:0];
  assign is_mult = (alu_op == ALU_OP_RTYPE) && (funct == FUNCT_MULT);

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      ALU_OP_ADD: alu_res = op_a + op_b;
      ALU_OP_SUB: alu_res = op_a - op_b;
      ALU_OP_OR:  alu_res = op_a | op_b;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_res = op_a + op_b;
          FUNCT_SUB: alu_res = op_a - op_b;
          FUNCT_AND: alu_res = op_a & op_b;
          FUNCT_OR:  alu_res = op_a | op_b;
          FUNCT_SLT: alu_res = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
          default:   alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // The MULT instruction stays parked in ID/EX while busy, so a new start
  // is only taken from IDLE; the operands are latched on the issue edge.
  assign mul_start = is_mult && !mul_busy;

  mul_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (op_a),
    .b_i       (op_b),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .product_o (mul_product)
  );

  assign ex_stall  = mul_start || (mul_busy && !mul_last);
  assign ex_result = mul_busy ? mul_product : alu_res;

  always_comb begin
    result_d  = '0;
    store_d   = '0;
    zero_d    = 1'b0;
    wr_addr_d = '0;
    ctrl_d    = CTRL_BUBBLE;
    if (!ex_stall) begin
      result_d  = ex_result;
      store_d   = rt_fwd;
      zero_d    = (ex_result == '0);
      wr_addr_d = reg_dst ? rd_addr : rt_addr;
      ctrl_d    = '{reg_w: reg_w, mem_w: mem_w, mem_r: mem_r, mem_to_reg: mem_to_reg};
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      result_q  <= '0;
      store_q   <= '0;
      zero_q    <= 1'b0;
      wr_addr_q <= '0;
      ctrl_q    <= CTRL_BUBBLE;
    end else begin
      result_q  <= result_d;
      store_q   <= store_d;
      zero_q    <= zero_d;
      wr_addr_q <= wr_addr_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign alu_result_out = result_q;
  assign store_data_out = store_q;
  assign zero_out       = zero_q;
  assign wr_addr_out    = wr_addr_q;
  assign reg_w_out      = ctrl_q.reg_w;
  assign mem_w_out      = ctrl_q.mem_w;
  assign mem_r_out      = ctrl_q.mem_r;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;

  localparam int unsigned DW = 32;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] rs_data, rt_data, imm, mem_fwd_data, wb_fwd_data;
  logic [4:0]    rs_addr, rt_addr, rd_addr, mem_wr_addr, wb_wr_addr;
  logic [1:0]    alu_op;
  logic          alu_src, reg_dst, reg_w, mem_w, mem_r, mem_to_reg;
  logic          mem_reg_w, wb_reg_w;
  logic          ex_stall, zero_out, reg_w_out, mem_w_out, mem_r_out, mem_to_reg_out;
  logic [DW-1:0] alu_result_out, store_data_out;
  logic [4:0]    wr_addr_out;

  ex_stage #(.DATA_W(DW), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .reg_w(reg_w),
    .mem_w(mem_w), .mem_r(mem_r), .mem_to_reg(mem_to_reg),
    .mem_reg_w(mem_reg_w), .mem_wr_addr(mem_wr_addr), .mem_fwd_data(mem_fwd_data),
    .wb_reg_w(wb_reg_w), .wb_wr_addr(wb_wr_addr), .wb_fwd_data(wb_fwd_data),
    .ex_stall(ex_stall),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .zero_out(zero_out), .wr_addr_out(wr_addr_out),
    .reg_w_out(reg_w_out), .mem_w_out(mem_w_out), .mem_r_out(mem_r_out),
    .mem_to_reg_out(mem_to_reg_out)
  );

  typedef struct packed {
    logic [31:0] rs, rt, imm;
    logic [4:0]  rsa, rta, rda;
    logic [1:0]  op;
    logic        alu_src, reg_dst, reg_w, mem_w, mem_r, m2r;
    logic        mrw;
    logic [4:0]  mwa;
    logic [31:0] mfd;
    logic        wrw;
    logic [4:0]  wwa;
    logic [31:0] wfd;
  } ins_t;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] store;
    logic        zero;
    logic [4:0]  wr;
    logic        reg_w, mem_w, mem_r, m2r;
  } out_t;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd_ref(ins_t i, logic [4:0] a, logic [31:0] v);
    if (FWD && i.mrw && a != 5'd0 && i.mwa == a) return i.mfd;
    if (FWD && i.wrw && a != 5'd0 && i.wwa == a) return i.wfd;
    return v;
  endfunction

  function automatic out_t expect_of(ins_t i);
    out_t o;
    logic [31:0] a, rtf, b;
    longint p;
    a   = fwd_ref(i, i.rsa, i.rs);
    rtf = fwd_ref(i, i.rta, i.rt);
    b   = i.alu_src ? i.imm : rtf;
    case (i.op)
      2'd0: o.res = a + b;
      2'd1: o.res = a - b;
      2'd3: o.res = a | b;
      default: begin
        case (i.imm[5:0])
          6'h20: o.res = a + b;
          6'h22: o.res = a - b;
          6'h24: o.res = a & b;
          6'h25: o.res = a | b;
          6'h2A: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h18: begin
            p = longint'($signed(a)) * longint'($signed(b));
            o.res = p[31:0];
          end
          default: o.res = 32'd0;
        endcase
      end
    endcase
    o.store = rtf;
    o.zero  = (o.res == 32'd0);
    o.wr    = i.reg_dst ? i.rda : i.rta;
    o.reg_w = i.reg_w;
    o.mem_w = i.mem_w;
    o.mem_r = i.mem_r;
    o.m2r   = i.m2r;
    return o;
  endfunction

  function automatic out_t observe();
    return {alu_result_out, store_data_out, zero_out, wr_addr_out,
            reg_w_out, mem_w_out, mem_r_out, mem_to_reg_out};
  endfunction

  function automatic ins_t rand_ins(bit mult);
    ins_t i;
    int unsigned sel;
    i.rs = $urandom; i.rt = $urandom; i.imm = $urandom;
    i.rsa = 5'($urandom_range(0, 3));
    i.rta = 5'($urandom_range(0, 3));
    i.rda = 5'($urandom_range(0, 31));
    i.op  = mult ? 2'd2 : 2'($urandom_range(0, 3));
    if (i.op == 2'd2) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: i.imm[5:0] = 6'h20;
        1: i.imm[5:0] = 6'h22;
        2: i.imm[5:0] = 6'h24;
        3: i.imm[5:0] = 6'h25;
        4: i.imm[5:0] = 6'h2A;
        default: i.imm[5:0] = 6'($urandom_range(0, 63));
      endcase
      if (i.imm[5:0] == 6'h18) i.imm[5:0] = 6'h3F;
      if (mult) i.imm[5:0] = 6'h18;
    end
    i.alu_src = mult ? 1'b0 : 1'($urandom_range(0, 1));
    i.reg_dst = 1'($urandom_range(0, 1));
    i.reg_w   = 1'($urandom_range(0, 1));
    i.mem_w   = 1'($urandom_range(0, 1));
    i.mem_r   = 1'($urandom_range(0, 1));
    i.m2r     = 1'($urandom_range(0, 1));
    i.mrw = 1'($urandom_range(0, 1)); i.mwa = 5'($urandom_range(0, 3)); i.mfd = $urandom;
    i.wrw = 1'($urandom_range(0, 1)); i.wwa = 5'($urandom_range(0, 3)); i.wfd = $urandom;
    return i;
  endfunction

  task automatic drive(ins_t i);
    rs_data = i.rs; rt_data = i.rt; imm = i.imm;
    rs_addr = i.rsa; rt_addr = i.rta; rd_addr = i.rda;
    alu_op = i.op; alu_src = i.alu_src; reg_dst = i.reg_dst;
    reg_w = i.reg_w; mem_w = i.mem_w; mem_r = i.mem_r; mem_to_reg = i.m2r;
    mem_reg_w = i.mrw; mem_wr_addr = i.mwa; mem_fwd_data = i.mfd;
    wb_reg_w = i.wrw; wb_wr_addr = i.wwa; wb_fwd_data = i.wfd;
  endtask

  // Outputs settle after the falling edge; sample 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ins_t n = '0;
    rst = 1'b1;
    drive(n);
    tick(); tick();
    checks++;
    if (observe() !== out_t'('0)) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", observe());
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall: got %b expected 0", ex_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype_add();
    ins_t i = '0;
    i.rs = 32'd5; i.rt = 32'd7; i.op = 2'd2; i.imm = 32'h20;
    i.rsa = 5'd1; i.rta = 5'd2; i.rda = 5'd9; i.reg_dst = 1'b1; i.reg_w = 1'b1;
    drive(i); tick();
    checks++;
    if (alu_result_out !== 32'd12 || wr_addr_out !== 5'd9 || reg_w_out !== 1'b1) begin
      failures++;
      $display("FAIL rtype_add: got res=%0d wr=%0d rw=%b expected res=12 wr=9 rw=1",
               alu_result_out, wr_addr_out, reg_w_out);
    end
  endtask

  task automatic test_forwarding();
    ins_t i = '0;
    logic [31:0] exp_v;
    i.rs = 32'd100; i.rt = 32'd1; i.op = 2'd0; i.rsa = 5'd3; i.rta = 5'd4;
    i.mrw = 1'b1; i.mwa = 5'd3; i.mfd = 32'd10;
    i.wrw = 1'b1; i.wwa = 5'd3; i.wfd = 32'd20;
    exp_v = FWD ? 32'd11 : 32'd101;
    drive(i); tick();
    checks++;
    if (alu_result_out !== exp_v) begin
      failures++;
      $display("FAIL fwd_mem_priority: got %0d expected %0d", alu_result_out, exp_v);
    end
    i.rsa = 5'd0; i.mwa = 5'd0; i.wwa = 5'd0;
    drive(i); tick();
    checks++;
    if (alu_result_out !== 32'd101) begin
      failures++;
      $display("FAIL fwd_addr0: got %0d expected 101", alu_result_out);
    end
  endtask

  task automatic test_sw();
    ins_t i = '0;
    logic [31:0] exp_st;
    i.rs = 32'h100; i.imm = 32'd8; i.alu_src = 1'b1; i.op = 2'd0; i.mem_w = 1'b1;
    i.rsa = 5'd6; i.rta = 5'd5; i.rt = 32'hDEAD;
    i.mrw = 1'b1; i.mwa = 5'd5; i.mfd = 32'hBEEF;
    exp_st = FWD ? 32'hBEEF : 32'hDEAD;
    drive(i); tick();
    checks++;
    if (alu_result_out !== 32'h108 || mem_w_out !== 1'b1 || store_data_out !== exp_st) begin
      failures++;
      $display("FAIL sw: got res=%h mw=%b st=%h expected res=108 mw=1 st=%h",
               alu_result_out, mem_w_out, store_data_out, exp_st);
    end
  endtask

  task automatic test_beq_slt();
    ins_t i = '0;
    i.op = 2'd1; i.rs = 32'd9; i.rt = 32'd9; i.rsa = 5'd1; i.rta = 5'd2;
    drive(i); tick();
    checks++;
    if (zero_out !== 1'b1 || alu_result_out !== 32'd0) begin
      failures++;
      $display("FAIL beq: got zero=%b res=%h expected zero=1 res=0", zero_out, alu_result_out);
    end
    i.op = 2'd2; i.imm = 32'h2A; i.rs = 32'hFFFF_FFFF; i.rt = 32'd1;
    drive(i); tick();
    checks++;
    if (alu_result_out !== 32'd1 || zero_out !== 1'b0) begin
      failures++;
      $display("FAIL slt: got res=%h zero=%b expected res=1 zero=0", alu_result_out, zero_out);
    end
  endtask

  task automatic test_alu_random(int n);
    ins_t i;
    out_t e;
    for (int k = 0; k < n; k++) begin
      i = rand_ins(1'b0);
      e = expect_of(i);
      drive(i); #1;
      checks++;
      if (ex_stall !== 1'b0) begin
        failures++;
        $display("FAIL alu_stall[%0d]: got %b expected 0", k, ex_stall);
      end
      tick();
      checks++;
      if (observe() !== e) begin
        failures++;
        $display("FAIL alu_rand[%0d]: got %h expected %h", k, observe(), e);
      end
    end
  endtask

  // Runs one MULT from issue through write-back; returns on the cycle
  // after the product lands so the caller can issue immediately.
  task automatic run_mult(ins_t i, string tag);
    ins_t cur;
    out_t e;
    int n;
    cur = i;
    e = expect_of(i);
    drive(cur); #1;
    n = 0;
    while (ex_stall === 1'b1 && n < 40) begin
      n++;
      tick();
      checks++;
      if (observe() !== out_t'('0)) begin
        failures++;
        $display("FAIL %s_bubble[%0d]: got %h expected 0", tag, n, observe());
      end
      // forwarding sources move on while the multiply runs
      cur.mfd = $urandom; cur.wfd = $urandom;
      drive(cur); #1;
    end
    checks++;
    if (n !== 32) begin
      failures++;
      $display("FAIL %s_stall_cycles: got %0d expected 32", tag, n);
    end
    e.store = expect_of(cur).store;
    tick();
    checks++;
    if (observe() !== e) begin
      failures++;
      $display("FAIL %s_product: got %h expected %h", tag, observe(), e);
    end
  endtask

  task automatic test_mult();
    ins_t i = '0;
    ins_t nx;
    out_t e;
    i.op = 2'd2; i.imm = 32'h18; i.rs = 32'hFFFF_FFFD; i.rt = 32'd7;
    i.rsa = 5'd1; i.rta = 5'd2; i.rda = 5'd8; i.reg_dst = 1'b1; i.reg_w = 1'b1;
    run_mult(i, "mult_dir");
    checks++;
    if (alu_result_out !== 32'hFFFF_FFEB || reg_w_out !== 1'b1) begin
      failures++;
      $display("FAIL mult_value: got res=%h rw=%b expected res=ffffffeb rw=1",
               alu_result_out, reg_w_out);
    end
    nx = rand_ins(1'b0);
    e = expect_of(nx);
    drive(nx); tick();
    checks++;
    if (observe() !== e) begin
      failures++;
      $display("FAIL mult_follow: got %h expected %h", observe(), e);
    end
    for (int k = 0; k < 3; k++) run_mult(rand_ins(1'b1), "mult_rand");
  endtask

  task automatic test_back_to_back();
    ins_t nx;
    out_t e;
    run_mult(rand_ins(1'b1), "b2b_first");
    run_mult(rand_ins(1'b1), "b2b_second");
    nx = rand_ins(1'b0);
    e = expect_of(nx);
    drive(nx); tick();
    checks++;
    if (observe() !== e) begin
      failures++;
      $display("FAIL b2b_follow: got %h expected %h", observe(), e);
    end
  endtask

  task automatic test_reset_mid_mult();
    ins_t i, nop, nx;
    out_t e;
    i = rand_ins(1'b1);
    i.reg_w = 1'b1;
    nop = '0;
    drive(i); #1;
    for (int k = 0; k < 11; k++) tick();   // issue cycle + BUSY cnt 0..9
    rst = 1'b1;
    drive(nop);
    tick();
    checks++;
    if (observe() !== out_t'('0)) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %h expected 0", observe());
    end
    checks++;
    if (ex_stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_stall: got %b expected 0", ex_stall);
    end
    rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      nx = rand_ins(1'b0);
      e = expect_of(nx);
      drive(nx); tick();
      checks++;
      if (observe() !== e) begin
        failures++;
        $display("FAIL rst_mid_after[%0d]: got %h expected %h", k, observe(), e);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rtype_add();
    test_forwarding();
    test_sw();
    test_beq_slt();
    test_alu_random(200);
    test_mult();
    test_back_to_back();
    test_reset_mid_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
